// File: rtl/switch_out_arbiter.sv
`default_nettype none
// switch_out_arbiter: round-robin drain of four switch output ports onto one
// registered valid/ready byte stream, forwarding whole packets with sop/eop markers.
module switch_out_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_0,
  input  logic              ready_1,
  input  logic              ready_2,
  input  logic              ready_3,
  input  logic [DATA_W-1:0] port_0,
  input  logic [DATA_W-1:0] port_1,
  input  logic [DATA_W-1:0] port_2,
  input  logic [DATA_W-1:0] port_3,
  output logic              read_0,
  output logic              read_1,
  output logic              read_2,
  output logic              read_3,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_CAP  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        ready_vec;
  logic [1:0]        last_grant;
  logic [1:0]        pick;
  logic [1:0]        cand;
  logic              any_ready;
  logic              ready_g;
  logic              rd_en;
  logic              wait_hit;
  logic              accept;
  logic [DATA_W-1:0] port_g;
  logic [WAIT_W-1:0] wait_cnt;
  logic [8:0]        byte_cnt;
  logic [7:0]        len;

  assign ready_vec = {ready_3, ready_2, ready_1, ready_0};
  assign any_ready = |ready_vec;
  assign ready_g   = ready_vec[grant];
  assign rd_en     = (state == S_RD) && ready_g;
  assign wait_hit  = (state == S_RD) && !ready_g && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign accept    = (state == S_OUT) && out_ready;

  assign read_0    = rd_en && (grant == 2'd0);
  assign read_1    = rd_en && (grant == 2'd1);
  assign read_2    = rd_en && (grant == 2'd2);
  assign read_3    = rd_en && (grant == 2'd3);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  always_comb begin
    port_g = port_0;
    case (grant)
      2'd1:    port_g = port_1;
      2'd2:    port_g = port_2;
      2'd3:    port_g = port_3;
      default: port_g = port_0;
    endcase
  end

  // Scan downwards so the closest ready port after last_grant wins.
  always_comb begin
    pick = last_grant + 2'd1;
    cand = last_grant;
    for (int i = 4; i >= 1; i--) begin
      cand = last_grant + 2'(i);
      if (ready_vec[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (any_ready) state_nxt = S_RD;
      S_RD: begin
        if (ready_g)       state_nxt = S_CAP;
        else if (wait_hit) state_nxt = S_IDLE;
      end
      S_CAP:  state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = out_eop ? S_IDLE : S_RD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= 2'd0;
      last_grant  <= 2'd3;
      wait_cnt    <= '0;
      byte_cnt    <= 9'd0;
      len         <= 8'd0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wait_hit;
      if (state == S_IDLE) begin
        byte_cnt <= 9'd0;
        wait_cnt <= '0;
        if (any_ready) grant <= pick;
      end
      if (rd_en) begin
        wait_cnt <= '0;
      end else if (state == S_RD) begin
        wait_cnt <= wait_hit ? '0 : wait_cnt + WAIT_W'(1);
      end
      // len still holds the previous packet for indices 0..2, but len+3 >= 3 keeps eop low there.
      if (state == S_CAP) begin
        out_data <= port_g;
        out_sop  <= (byte_cnt == 9'd0);
        out_eop  <= (byte_cnt == ({1'b0, len} + 9'd3));
        if (byte_cnt == 9'd2) len <= port_g[7:0];
        byte_cnt <= byte_cnt + 9'd1;
      end
      if ((accept && out_eop) || wait_hit) last_grant <= grant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_out_arbiter.sv
`default_nettype none
// Scoreboard bench for switch_out_arbiter: port models feed bytes, a whole-packet
// round-robin model predicts the output stream, and a monitor compares every accepted byte.
module tb_switch_out_arbiter;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 10;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [1:0] g;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        ready = 4'd0;
  logic [DATA_W-1:0] port_d [4];
  logic              out_ready = 1'b1;
  logic              read_0, read_1, read_2, read_3;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_sop, out_eop, busy, err_timeout;
  logic [1:0]        grant;
  logic [3:0]        rd_vec;

  logic [7:0] pq    [4][$];
  exp_t       stg   [4][$];
  int         pkt_n [4][$];
  exp_t       expq  [$];
  int         m_last = 3;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         acc_cnt = 0;
  int         last_acc_cyc = 0;
  int         err_cnt = 0;
  int         err_cyc = 0;
  int         rd_total [4];
  logic [3:0] rd_seen = 4'd0;
  logic       ordy_rand = 1'b0;
  logic       ordy_val = 1'b1;

  assign rd_vec = {read_3, read_2, read_1, read_0};

  switch_out_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ready_0(ready[0]), .ready_1(ready[1]), .ready_2(ready[2]), .ready_3(ready[3]),
    .port_0(port_d[0]), .port_1(port_d[1]), .port_2(port_d[2]), .port_3(port_d[3]),
    .read_0(read_0), .read_1(read_1), .read_2(read_2), .read_3(read_3),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .grant(grant), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Port models: a read seen in cycle n presents the next byte in cycle n+1.
  initial begin
    for (int k = 0; k < 4; k++) port_d[k] = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (rd_seen[k] && pq[k].size() > 0) port_d[k] = pq[k].pop_front();
        ready[k] = (pq[k].size() > 0);
      end
      out_ready = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_val;
    end
  end

  initial begin
    exp_t e;
    logic pv;
    logic [DATA_W+1:0] phold;
    pv = 1'b0;
    phold = '0;
    forever begin
      @(negedge clk);
      rd_seen = rd_vec;
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (rd_vec != 4'd0) begin
          chk("read_onehot", $countones(rd_vec), 1);
          chk("read_matches_grant", 32'(rd_vec), 32'(4'b0001 << grant));
          chk("read_while_byte_pending", 32'(out_valid), 0);
          for (int k = 0; k < 4; k++) begin
            if (rd_vec[k]) begin
              rd_total[k]++;
              chk("read_port_has_byte", 32'(pq[k].size() > 0), 1);
            end
          end
        end
        if (pv) chk("backpressure_hold", {out_valid, out_sop, out_eop, out_data}, {1'b1, phold});
        pv = out_valid && !out_ready;
        phold = {out_sop, out_eop, out_data};
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("unexpected_out_byte", expq.size(), 1);
          end else begin
            e = expq.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_sop", out_sop, e.sop);
            chk("out_eop", out_eop, e.eop);
            chk("out_grant", grant, e.g);
          end
          acc_cnt++;
          last_acc_cyc = cyc;
        end
        if (err_timeout) begin
          err_cnt++;
          err_cyc = cyc;
        end
      end
    end
  end

  // Builds a packet: nbytes < len+4 models a port that stalls mid-packet.
  task automatic gen_pkt(input int p, input int len, input int nbytes);
    logic [7:0] d;
    exp_t e;
    for (int i = 0; i < len + 4; i++) begin
      d = (i == 2) ? 8'(len) : 8'($urandom);
      if (i < nbytes) begin
        pq[p].push_back(d);
        e.d = d;
        e.sop = (i == 0);
        e.eop = (i == len + 3);
        e.g = 2'(p);
        stg[p].push_back(e);
      end
    end
    pkt_n[p].push_back((nbytes < len + 4) ? nbytes : len + 4);
  endtask

  // Whole packets leave in round-robin order starting after the last served port.
  task automatic model_rr();
    int p;
    int n;
    bit found;
    p = 0;
    do begin
      found = 1'b0;
      for (int i = 1; i <= 4 && !found; i++) begin
        p = (m_last + i) % 4;
        if (pkt_n[p].size() > 0) found = 1'b1;
      end
      if (found) begin
        n = pkt_n[p].pop_front();
        repeat (n) expq.push_back(stg[p].pop_front());
        m_last = p;
      end
    end while (found);
  endtask

  function automatic int pending();
    int s;
    s = expq.size();
    for (int k = 0; k < 4; k++) s += pq[k].size();
    return s;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((pending() != 0 || busy) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 32'((pending() == 0) && !busy), 1);
  endtask

  task automatic wait_acc(input int target, input string name);
    int n;
    n = 0;
    while (acc_cnt < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 32'(acc_cnt >= target), 1);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 32'(out_valid), 1);
  endtask

  task automatic flush();
    for (int k = 0; k < 4; k++) begin
      pq[k].delete();
      stg[k].delete();
      pkt_n[k].delete();
    end
    expq.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    flush();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_last = 3;
  endtask

  initial begin
    int t0;
    int n;
    int a0;
    int e0;
    for (int k = 0; k < 4; k++) rd_total[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, out_sop, out_eop, busy, err_timeout, grant, rd_vec, out_data}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single LEN=3 packet on port 2 with first-byte latency.
    @(posedge clk); #1;
    gen_pkt(2, 3, 7);
    model_rr();
    n = 0;
    while (!ready[2] && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("single_ready_rise", 32'(ready[2]), 1);
    t0 = cyc;
    @(negedge clk); #1;
    chk("single_grant_c1", {busy, grant, rd_vec}, {1'b1, 2'd2, 4'b0100});
    @(negedge clk); #1;
    chk("single_valid_c2", 32'(out_valid), 0);
    @(negedge clk); #1;
    chk("single_valid_c3", 32'(out_valid), 1);
    chk("single_latency", cyc - t0, 3);
    drain("single_drain", 200);
    chk("single_read2_count", rd_total[2], 7);
    chk("single_other_reads", rd_total[0] + rd_total[1] + rd_total[3], 0);

    // All four ports from reset, then ports 0 and 1 again.
    do_reset();
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) gen_pkt(k, 0, 4);
    model_rr();
    drain("rr_four_drain", 400);
    @(posedge clk); #1;
    gen_pkt(0, 0, 4);
    gen_pkt(1, 0, 4);
    model_rr();
    drain("rr_two_drain", 400);

    // Five-cycle stall on byte 3 of a LEN=2 packet.
    @(posedge clk); #1;
    a0 = acc_cnt;
    gen_pkt(3, 2, 5);
    model_rr();
    wait_acc(a0 + 2, "bp_first_bytes");
    ordy_val = 1'b0;
    wait_valid("bp_byte3_valid");
    repeat (4) @(negedge clk);
    #1;
    chk("bp_still_stalled", {out_valid, out_ready}, 2'b10);
    ordy_val = 1'b1;
    drain("bp_drain", 200);

    // LEN boundaries.
    @(posedge clk); #1;
    gen_pkt(1, 0, 4);
    gen_pkt(1, 255, 259);
    model_rr();
    drain("len_bound_drain", 2000);

    // Randomised mix with random backpressure.
    @(posedge clk); #1;
    ordy_rand = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        t0 = $urandom_range(0, 15);
        gen_pkt(k, t0, t0 + 4);
      end
    end
    model_rr();
    drain("random_drain", 20000);
    ordy_rand = 1'b0;

    // Port 1 stalls after byte 4; port 2 becomes pending meanwhile.
    @(posedge clk); #1;
    e0 = err_cnt;
    gen_pkt(1, 6, 4);
    model_rr();
    n = 0;
    while (!(busy && grant == 2'd1) && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("timeout_granted_1", {busy, grant}, {1'b1, 2'd1});
    gen_pkt(2, 3, 7);
    model_rr();
    n = 0;
    while (err_cnt == e0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("timeout_err_seen", err_cnt - e0, 1);
    chk("timeout_latency", err_cyc - last_acc_cyc, TIMEOUT + 1);
    chk("timeout_idle_on_err", 32'(busy), 0);
    drain("timeout_drain", 400);
    chk("timeout_single_pulse", err_cnt - e0, 1);

    // Asynchronous reset while byte 3 sits in OUT.
    @(posedge clk); #1;
    a0 = acc_cnt;
    gen_pkt(0, 4, 8);
    model_rr();
    wait_acc(a0 + 2, "rst_first_bytes");
    ordy_val = 1'b0;
    wait_valid("rst_byte3_valid");
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {out_valid, out_sop, out_eop, busy, err_timeout, grant, rd_vec, out_data}, 0);
    flush();
    m_last = 3;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ordy_val = 1'b1;
    @(posedge clk); #1;
    gen_pkt(3, 1, 5);
    gen_pkt(0, 1, 5);
    model_rr();
    drain("post_reset_drain", 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run not finished at t=%0t, required finish before 600000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/switch_out_arbiter.md
# switch_out_arbiter

Round-robin drain controller for the four output ports of the switch. It watches `ready_0..3` and grants one port at a time. For the granted port it issues one-byte `read_N` pulses and merges the port's packet bytes onto a single registered output stream with valid/ready backpressure and start/end markers. It sits between the switch output ports and the downstream consumer (checker, host FIFO), and guarantees whole-packet, non-interleaved forwarding.

## Interface
- `DATA_W`, 8: byte width of `port_N` and `out_data`.
- `TIMEOUT`, 255: maximum cycles to wait on a deasserted `ready_g` mid-packet before the packet is aborted; minimum 1.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ready_0..ready_3`  in  1 each  port N holds at least one unread byte.
- `port_0..port_3`  in  DATA_W each  port N data, valid in the cycle after `read_N` is high.
- `read_0..read_3`  out  1 each  one-cycle read strobe to port N.
- `out_data`  out  DATA_W  forwarded byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_sop` / `out_eop`  out  1  first / last byte of a packet; qualified by `out_valid`.
- `out_ready`  in  1  downstream accepts a byte when `out_valid && out_ready`.
- `grant`  out  2  index of the port currently being drained; holds the last value when idle.
- `busy`  out  1  a packet is in progress.
- `err_timeout`  out  1  one-cycle pulse when a packet is aborted.

## Operation
- Packet format: byte0 DA, byte1 SA, byte2 LEN, then LEN payload bytes, then 1 FCS byte. Total bytes = LEN+4, counted in a 9-bit counter. LEN=0 is legal and gives 4 bytes.
- FSM states and transitions:
  - IDLE: if any `ready_k` is high, latch `grant` and go to RD.
  - RD: `read_g`=1 for one cycle, then go to CAP. If `ready_g`=0 on entry, stay in RD with the read strobe low and increment the wait counter.
  - CAP: register `port_g` into `out_data` and increment the byte count, then go to OUT.
  - OUT: hold `out_valid`=1 until accepted. On accept, go to RD if more bytes remain. After the last byte, go to IDLE and set last_grant = `grant`.
- Arbitration: round-robin, starting from last_grant+1 (mod 4). Reset sets last_grant=3, so port 0 has top priority first.
- The arbiter samples ready flags only in IDLE. A port that asserts ready mid-packet waits its turn.
- `out_sop`=1 with byte index 0. `out_eop`=1 with byte index LEN+3.
- LEN is captured from byte index 2. The end test uses the captured LEN from that point on.
- Wait counter: clears on every issued read. When it reaches TIMEOUT, the FSM pulses `err_timeout`, drops `busy`, updates last_grant, and returns to IDLE. The aborted packet emits no `out_eop`.
- Only one `read_N` is high in any cycle. No read is issued while a byte is pending in CAP or OUT.
- Reset (asserted at any time, including mid-packet): FSM goes to IDLE, all outputs go to 0 (`grant`=0, `out_data`=0), and counters clear. Bytes already read from the port are lost.

## Timing
- `ready_k` rises in cycle 0 with the FSM in IDLE:
  - `grant` and `busy` are valid in cycle 1.
  - `read_k` is high in cycle 1.
  - `port_k` is sampled in cycle 2.
  - `out_valid` is high in cycle 3.
- With `out_ready` held high, throughput is one byte per 3 cycles: RD, CAP, OUT. The next read is in the cycle after acceptance.
- `out_data`, `out_sop` and `out_eop` stay stable while `out_valid && !out_ready`.
- After the final accept, the FSM is in IDLE in the next cycle. The next grant is decided in that IDLE cycle.
- `err_timeout` asserts in the cycle after the wait counter reaches TIMEOUT. The FSM is in IDLE in the same cycle.
- `busy` is high from the cycle `grant` latches through the cycle of the final accept or the abort.

## Test plan
- Single packet on port 2, LEN=3, `out_ready`=1: 7 bytes out in order with `out_sop` on byte 1 and `out_eop` on byte 7. `read_2` pulses 7 times and no other read is asserted. The first `out_valid` comes 3 cycles after `ready_2` rises.
- All four ports ready from reset, each with a LEN=0 packet: ports drain in order 0,1,2,3 with 4 bytes each. Re-asserting `ready_0` and `ready_1` after the port 3 packet gives the order 0 then 1.
- Backpressure: `out_ready`=0 for 5 cycles on byte 3 of a LEN=2 packet. `out_data`, `out_sop` and `out_eop` hold and no `read_N` is issued. The remaining bytes follow in order once `out_ready` returns.
- LEN boundary values: LEN=0 gives 4 bytes and LEN=255 gives 259 bytes, each with exactly one `out_eop` on the final byte and no counter wrap.
- Timeout with TIMEOUT=10: `ready_1` drops after byte 4. `err_timeout` pulses once after 10 wait cycles with no `out_eop`, and a pending `ready_2` is granted next.
- Reset mid-packet, asserted during OUT of byte 3: all outputs read 0 asynchronously. After release, port 0 is granted first when `ready_0` and `ready_3` are both high.
